// File: rtl/pool_window_gather.sv
// Gathers a raster pixel stream into non-overlapping 2x2 windows for the max-pooling stage.
// Optional POOL_WIN_RELU_EN: negative inputs are clamped to zero on entry.
module pool_window_gather #(
    parameter int DATA_W = 20,
    parameter int IFM_W  = 28,
    parameter int IFM_H  = 28,
    parameter int POOL_  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_data [POOL_-1:0],
    output logic              frame_done
);
    localparam int CW = (IFM_W > 1) ? $clog2(IFM_W) : 1;
    localparam int RW = (IFM_H > 1) ? $clog2(IFM_H) : 1;

    if (POOL_ != 4) begin : g_pool_chk
        $fatal(1, "pool_window_gather: POOL_ must be 4 (2x2 window)");
    end

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] rowbuf [IFM_W];
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] pix;
    logic              acc, col_last, row_last, form;

`ifdef POOL_WIN_RELU_EN
    assign pix = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign pix = in_data;
`endif

    assign in_ready = win_ready || !win_valid;
    assign acc      = in_valid && in_ready;
    assign col_last = (col == CW'(IFM_W - 1));
    assign row_last = (row == RW'(IFM_H - 1));
    // Odd col on an odd row is always a bottom-right; a trailing odd column is even-indexed.
    assign form     = acc && row[0] && col[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Row buffer holds only data; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (acc && !row[0]) rowbuf[col] <= pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold <= '0;
        else if (acc && row[0] && !col[0]) hold <= pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            for (int k = 0; k < POOL_; k++) win_data[k] <= '0;
        end else if (form) begin
            win_valid   <= 1'b1;
            win_data[0] <= rowbuf[col - CW'(1)];
            win_data[1] <= rowbuf[col];
            win_data[2] <= hold;
            win_data[3] <= pix;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= acc && col_last && row_last;
    end
endmodule

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
- Upstream neighbour of the max-pooling stage.
- Accepts a raster-order stream of conv/activation results, one pixel per handshake.
- Buffers one even row and assembles non-overlapping 2x2 windows (stride 2).
- Presents each window as POOL_ parallel words that drive the max-pooling stage's ifm_input directly.

Parameters:
- DATA_W, 20, pixel width in bits (signed two's complement); matches the pooling stage's input_width.
- IFM_W, 28, pixels per row.
- IFM_H, 28, rows per frame.
- POOL_, 4, words per window; fixed at 4 (2x2). Any other value is a fatal elaboration error.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  DATA_W  pixel, raster order, row-major.
- win_valid  output  1  win_data holds a complete window.
- win_ready  input  1  downstream accepts the window this cycle.
- win_data  output  DATA_W x POOL_ (unpacked [POOL_-1:0])  window: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - win_valid=0, win_data all 0, frame_done=0.
  - col=0, row=0, holding register=0.
  - Row buffer contents are don't-care.
  - in_ready=1 once out of reset.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - in_ready = win_ready || !win_valid (combinational; skid-free, single output register).
  - Output transfer = win_valid && win_ready.
  - win_data is stable while win_valid && !win_ready.
- Counters:
  - col runs 0..IFM_W-1, row runs 0..IFM_H-1; both advance only on accept.
  - col wraps to 0 and row increments at col==IFM_W-1.
  - row wraps to 0 after the last pixel of the frame.
- Even rows (row[0]==0): the accepted pixel is written to rowbuf[col].
- Odd rows:
  - At even col, the pixel is stored in the holding register.
  - At odd col, a window is formed: {rowbuf[col-1], rowbuf[col], hold, in_data}.
- Window output:
  - The window is registered into win_data, with win_valid=1 on the next cycle (latency 1 from accepting the bottom-right pixel).
  - win_valid clears on transfer unless a new window loads in the same cycle.
- Boundaries:
  - Odd IFM_W: the last column of every row is accepted and discarded; it never forms a window.
  - Odd IFM_H: the last row is accepted and discarded.
  - Windows per frame = floor(IFM_W/2)*floor(IFM_H/2).
- frame_done:
  - Registered; high for exactly one cycle after the accept of pixel (IFM_H-1, IFM_W-1).
  - Independent of win_ready.
  - May coincide with win_valid of the final window.
- Back-to-back frames: the next frame's first pixel may be accepted the cycle after the last; no bubble is required.
- Reset mid-frame:
  - Partial windows are discarded.
  - Counters restart at (0,0).
  - A pending win_valid drops immediately (async).
- No arithmetic on data: values pass through unmodified, except under the optional feature.

Optional Feature:
- POOL_WIN_RELU_EN defined:
  - Each accepted in_data with MSB=1 (negative) is replaced by 0 before it reaches the row buffer, holding register or window.
  - All other values pass unchanged; no extra latency.
- Not defined: data passes through unmodified; negative values reach win_data as-is.

Test Plan:
- Basic frame: IFM_W=4, IFM_H=4, win_ready=1, stream 0..15 continuously.
  - Windows, in order: {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
  - Each window appears 1 cycle after its bottom-right pixel (5, 7, 13, 15) is accepted.
  - frame_done pulses once, the cycle after pixel 15 is accepted.
- Backpressure: same stream, win_ready held 0 for 5 cycles after the first window.
  - win_data stays {0,1,4,5}.
  - in_ready=0 during the stall, and in_data is not consumed.
  - After release, all 4 windows arrive correct with no loss or duplication.
- Odd dimensions: IFM_W=5, IFM_H=3, stream 0..14.
  - Exactly 2 windows: {0,1,5,6}, {2,3,7,8}.
  - Pixels 4, 9 and 10..14 produce no window.
  - frame_done fires after pixel 14 is accepted.
- Reset mid-frame: IFM_W=4, IFM_H=4; assert rst_n=0 after pixel 6 is accepted, release, then stream 100..115.
  - First window is {100,101,104,105}; nothing from the aborted frame appears.
- Input gaps plus frame chaining: random in_valid deassertion over two consecutive 4x4 frames.
  - Window sequence and values match the gap-free case.
  - Exactly 2 frame_done pulses.
- RELU (POOL_WIN_RELU_EN defined): IFM_W=2, IFM_H=2, inputs 20'hFFFFD, 7, 20'h80000, 3.
  - Window {0,7,0,3}.
  - Without the macro: {20'hFFFFD, 7, 20'h80000, 3}.
